bin_map_packer: RTL

//  Consumer end of the threshold-comparator output stream: takes the 1-bit-per-bin decisions
//  (iEN/iDATA, bin index iCNT) and packs them LSB-first into WW-bit words for the CNN feature

---
 rtl/bin_map_pkg.sv | 30 +++
 rtl/bin_word_fifo.sv | 56 +++++
 rtl/bin_map_packer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bin_map_pkg.sv
// rtl/bin_map_pkg.sv - shared constants, state encodings and FIFO entry layout for the bin map packer
// Purpose : default geometry of the packer, derived word count, FSM state codes.
// Ports   : none (package).
package bin_map_pkg;

    localparam int WW_DEF         = 32;
    localparam int CW_DEF         = 17;
    localparam int FRAME_BITS_DEF = 4096;
    localparam int DEPTH_DEF      = 4;
    localparam int AW_DEF         = 8;

    // Number of packed words needed to hold a frame, rounding the tail word up.
    function automatic int words_for(input int frame_bits, input int ww);
        return (frame_bits + ww - 1) / ww;
    endfunction

    localparam int WORDS_PER_FRAME = words_for(FRAME_BITS_DEF, WW_DEF);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Entry layout at default geometry; the top packs the same {last, addr, data} order.
    typedef struct packed {
        logic                last;
        logic [AW_DEF-1:0]   addr;
        logic [WW_DEF-1:0]   data;
    } fifo_entry_t;

endpackage

// File: rtl/bin_word_fifo.sv
// rtl/bin_word_fifo.sv - synchronous first-word-fall-through FIFO for packed words
// Purpose : DEPTH-entry FWFT buffer; head entry visible on rd_data_o whenever not empty.
// Ports   : clk_i, rst_i (async high), clr_i (sync flush), wr_en_i/wr_data_i (push),
//           rd_en_i (pop head), rd_data_o (head), full_o, empty_o.
module bin_word_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic          wr_fire, rd_fire;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign rd_fire = rd_en_i && !empty_o && !clr_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_fire = wr_en_i && (!full_o || rd_fire) && !clr_i;

    assign rd_data_o = mem[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_ptr_q[PW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/bin_map_packer.sv
// rtl/bin_map_packer.sv - packs 1-bit bin decisions LSB-first into words behind a valid/ready FIFO
// Purpose : checks bin ordering, zero-pads the frame tail word, flags last word, buffers output.
// Ports   : iCLK, iRST (async high), iCLR (sync clear), iEN/iDATA/iCNT (bin stream in),
//           oVALID/iREADY/oDATA/oADDR/oLAST (word stream out), oDONE (frame delivered pulse),
//           oERR (sticky ordering error), oOVF (sticky dropped word).
module bin_map_packer
    import bin_map_pkg::*;
#(
    parameter int WW         = WW_DEF,
    parameter int CW         = CW_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic          iDATA,
    input  logic [CW-1:0] iCNT,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [WW-1:0] oDATA,
    output logic [AW-1:0] oADDR,
    output logic          oLAST,
    output logic          oDONE,
    output logic          oERR,
    output logic          oOVF
);

    localparam int            BW       = $clog2(WW);
    localparam int            EW       = 1 + AW + WW;
    localparam logic [CW-1:0] LAST_BIN = CW'(FRAME_BITS - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] exp_q, exp_d;
    logic [WW-1:0] sr_q, sr_d;
    logic [BW-1:0] bpos_q, bpos_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          lost_q, lost_d;

    logic [WW-1:0] hold_data_q;
    logic [AW-1:0] hold_addr_q;
    logic          hold_last_q;

    logic          accept, is_last_bin, complete, pop, dropped;
    logic [WW-1:0] word;
    logic [EW-1:0] wr_entry, head;
    logic          fifo_full, fifo_empty;
    logic          head_last;
    logic [AW-1:0] head_addr;
    logic [WW-1:0] head_data;

    assign accept = iEN && (((state_q == S_IDLE) && (iCNT == '0)) ||
                            ((state_q == S_PACK) && (iCNT == exp_q)));
    assign is_last_bin = (iCNT == LAST_BIN);
    // Bits above bpos_q are already zero, so the tail word comes out zero-padded.
    assign word     = sr_q | ({{(WW-1){1'b0}}, iDATA} << bpos_q);
    assign complete = accept && ((bpos_q == BW'(WW - 1)) || is_last_bin);
    assign wr_entry = {is_last_bin, addr_q, word};

    assign {head_last, head_addr, head_data} = head;

    assign pop     = !fifo_empty && iREADY && !iCLR;
    assign dropped = complete && fifo_full && !pop;

    bin_word_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (iCLK),
        .rst_i     (iRST),
        .clr_i     (iCLR),
        .wr_en_i   (complete),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign oVALID = !fifo_empty;
    assign oDATA  = fifo_empty ? hold_data_q : head_data;
    assign oADDR  = fifo_empty ? hold_addr_q : head_addr;
    assign oLAST  = fifo_empty ? hold_last_q : head_last;
    assign oDONE  = pop && head_last;
    assign oERR   = err_q;
    assign oOVF   = ovf_q;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        sr_d    = sr_q;
        bpos_d  = bpos_q;
        addr_d  = addr_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        lost_d  = lost_q;

        if (iEN && !accept) begin
            err_d = 1'b1;
        end

        if (accept) begin
            exp_d   = iCNT + CW'(1);
            state_d = is_last_bin ? S_DRAIN : S_PACK;
            if (complete) begin
                sr_d   = '0;
                bpos_d = '0;
                addr_d = is_last_bin ? '0 : addr_q + AW'(1);
            end else begin
                sr_d   = word;
                bpos_d = bpos_q + BW'(1);
            end
        end

        if (dropped) begin
            ovf_d = 1'b1;
            if (is_last_bin) lost_d = 1'b1;
        end

        // A dropped last word never reaches the output, so the frame ends once the
        // surviving words have drained instead of on a last-word acceptance.
        if (state_q == S_DRAIN) begin
            if (oDONE) begin
                state_d = S_IDLE;
            end else if (lost_q && fifo_empty) begin
                state_d = S_IDLE;
                lost_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            sr_q        <= '0;
            bpos_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            lost_q      <= 1'b0;
            hold_data_q <= '0;
            hold_addr_q <= '0;
            hold_last_q <= 1'b0;
        end else if (iCLR) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            sr_q        <= '0;
            bpos_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            lost_q      <= 1'b0;
            hold_data_q <= '0;
            hold_addr_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            sr_q    <= sr_d;
            bpos_q  <= bpos_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
            // Keep the departing head so the outputs hold when the FIFO runs empty.
            if (pop) begin
                hold_data_q <= head_data;
                hold_addr_q <= head_addr;
                hold_last_q <= head_last;
            end
        end
    end

endmodule
